mc_cpu_core: RTL and testbench
==============================

# mc_cpu_core

Parametrised multi-cycle CPU core: fetch/decode/execute/memory/writeback FSM, 16-entry register file, ALU, branch and conditional-move logic. Instruction and data memories sit outside the block behind req/ack handshakes, so wait-state memories are supported. It is the generalised successor of the fixed 32-bit single-memory CPU top level, adding a configurable data width, a configurable reset vector, a retired-instruction counter and debug register selection. It is the top of the processor under the board wrapper.

## Interface
- DW, 32: data/register width, 16..64.
- AW, 32: address/PC width, 16..32.
- RESET_PC, 0: PC value after reset.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-low.
- continue  in  1  resume from HALT.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  AW  fetch address (= PC).
- imem_rdata  in  32  instruction word.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  AW  low AW bits of the effective address.
- dmem_wdata  out  DW  store data.
- dmem_rdata  in  DW  load data.
- dmem_ack  in  1  data transfer complete.
- dbg_sel  in  4  register index for debug.
- debug  out  DW  combinational reg[dbg_sel].
- halted  out  1  core in HALT.
- retired  out  32  retired-instruction count, wraps at 2^32.

## Operation
- Instruction fields: op = [31:28], fn = [27:24], rs1 = [23:20], rs2 = [19:16], rd = [15:12], imm = sign-extend [15:0] to DW.
- All 16 registers are general purpose. R0 is not hardwired.
- op 0, ALU reg: rd = rs1 fn rs2.
- op 1, ALU imm: rd = rs1 fn imm.
- op 2, LD: rd = mem[rs1 + imm].
- op 3, ST: mem[rs1 + imm] = rd.
- op 4, BR: if cond(rs1) then PC = PC + 4 + imm, else PC + 4.
  - fn 0 = always.
  - fn 1 = rs1 == 0.
  - fn 2 = rs1 != 0.
  - fn 3 = rs1 < 0 (signed).
  - Other fn values are never taken.
- op 5, CMOV: if rs2 != 0 then rd = rs1, else rd is unchanged (no write).
- op 15: HALT.
- All other ops are NOPs, which retire.
- ALU fn codes, DW-bit modulo arithmetic:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not rs1.
  - 6 sll, 7 srl, 8 sra; shift amount is B[log2(DW)-1:0].
  - 9 slt (signed, result 1/0).
  - Any other fn gives 0.
- FSM states:
  - FETCH: imem_req = 1 until imem_ack. On ack, IR <= imem_rdata, PC <= PC + 4, go to DECODE.
  - DECODE: A <= reg[rs1], B <= reg[rs2] or imm, D <= reg[rd]. HALT op goes to HALT; every other op goes to EXEC.
  - EXEC: compute the ALU result or effective address. BR loads PC if taken, retires, then goes to FETCH. LD/ST go to MEM. NOP retires, then goes to FETCH. Others go to WB.
  - MEM: dmem_req = 1 until dmem_ack, with address/wdata/we held stable. On ack, LD latches rdata and goes to WB; ST retires and goes to FETCH.
  - WB: write rd (skipped for untaken CMOV), retire, go to FETCH.
  - HALT: halted = 1, retires once on entry. continue = 1 goes to FETCH at the already-incremented PC. continue outside HALT is ignored.
- Handshakes:
  - A transfer completes on a rising edge where req and ack are both 1.
  - req deasserts in the following cycle.
  - ack while req = 0 is ignored.
  - Ack in the same cycle req rises is legal.

## Timing
- Reset (reset = 0 at an edge), applied in the same edge:
  - PC = RESET_PC.
  - All registers, IR, A, B, D = 0.
  - State = FETCH.
  - retired = 0, halted = 0.
  - imem_req/dmem_req/dmem_we = 0 in the cycle after reset; imem_req = 1 from the first cycle after reset release.
  - Reset mid-transaction abandons the request. A late ack is ignored.
- Zero-wait-state latency, in cycles:
  - ALU/CMOV: 4.
  - LD: 5.
  - ST: 4.
  - BR: 3.
  - NOP: 3.
  - HALT: 2 until halted = 1.
- Each wait cycle of ack adds exactly one cycle.
- retired increments at the edge leaving the retiring state. debug reflects the write from the cycle after WB.
- PC and address arithmetic wrap modulo 2^AW.

## Test plan
- Reset release with RESET_PC = 0x100 and ack tied high → imem_addr = 0x100 in the first cycle after reset release; retired = 0; all registers read 0 via debug.
- Program "ADDI R1, R0, 5; ADDI R2, R0, -3; ADD R3, R1, R2; SRA R4, R2, 1" → R3 = 2, R4 = 0xFFFFFFFF; retired = 4 after 16 cycles.
- ST R3 to address 0x40, then LD R5 from 0x40, with dmem_ack delayed 3 cycles → dmem_req held with stable address for 4 cycles; R5 = 2; LD total 8 cycles.
- BR fn 2 on R1 = 5 with imm = -8 → next fetch address is PC + 4 - 8. With R1 = 0, the fall-through PC + 4 is fetched.
- CMOV R6, R1, R0 (rs2 = 0) → R6 unchanged. Then HALT → halted = 1, no imem_req. A 1-cycle continue pulse → fetch resumes at HALT address + 4.
- Reset asserted while dmem_req = 1 and ack pending → next cycle dmem_req = 0 and PC = RESET_PC. A stray ack 1 cycle later changes no state.

Source files
------------

// File: rtl/mc_cpu_core.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer, 16 x DW register file, ALU, branch and CMOV.
// Zero-wait latency is 3..5 cycles per instruction; each cycle an imem/dmem ack is withheld stretches the owning state by one.
module mc_cpu_core #(
    parameter int            DW       = 32,
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          continue_i,
    output logic          imem_req_o,
    output logic [AW-1:0] imem_addr_o,
    input  logic [31:0]   imem_rdata_i,
    input  logic          imem_ack_i,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [AW-1:0] dmem_addr_o,
    output logic [DW-1:0] dmem_wdata_o,
    input  logic [DW-1:0] dmem_rdata_i,
    input  logic          dmem_ack_i,
    input  logic [3:0]    dbg_sel_i,
    output logic [DW-1:0] debug_o,
    output logic          halted_o,
    output logic [31:0]   retired_o
);

    localparam int SW = $clog2(DW);

    localparam logic [3:0] OP_ALUR = 4'd0;
    localparam logic [3:0] OP_ALUI = 4'd1;
    localparam logic [3:0] OP_LD   = 4'd2;
    localparam logic [3:0] OP_ST   = 4'd3;
    localparam logic [3:0] OP_BR   = 4'd4;
    localparam logic [3:0] OP_CMOV = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        pc_q, pc_d;
    logic [31:0]          ir_q, ir_d;
    logic [DW-1:0]        a_q, a_d;
    logic [DW-1:0]        b_q, b_d;
    logic [DW-1:0]        d_q, d_d;
    logic [DW-1:0]        y_q, y_d;
    logic [31:0]          ret_q, ret_d;
    logic [DW-1:0]        rf_q [16];
    logic                 rf_we;

    logic [3:0]           op, fn, rs1, rs2, rd;
    logic signed [15:0]   imm16;
    logic [DW-1:0]        imm_dw;
    logic [AW-1:0]        imm_aw;
    logic [DW-1:0]        alu;
    logic                 br_taken;

    assign op     = ir_q[31:28];
    assign fn     = ir_q[27:24];
    assign rs1    = ir_q[23:20];
    assign rs2    = ir_q[19:16];
    assign rd     = ir_q[15:12];
    assign imm16  = ir_q[15:0];
    assign imm_dw = DW'(imm16);
    assign imm_aw = AW'(imm16);

    always_comb begin
        alu = '0;
        case (fn)
            4'd0:    alu = a_q + b_q;
            4'd1:    alu = a_q - b_q;
            4'd2:    alu = a_q & b_q;
            4'd3:    alu = a_q | b_q;
            4'd4:    alu = a_q ^ b_q;
            4'd5:    alu = ~a_q;
            4'd6:    alu = a_q << b_q[SW-1:0];
            4'd7:    alu = a_q >> b_q[SW-1:0];
            4'd8:    alu = DW'($signed(a_q) >>> b_q[SW-1:0]);
            4'd9:    alu = DW'($signed(a_q) < $signed(b_q));
            default: alu = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (fn)
            4'd0:    br_taken = 1'b1;
            4'd1:    br_taken = (a_q == '0);
            4'd2:    br_taken = (a_q != '0);
            4'd3:    br_taken = a_q[DW-1];
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        d_d        = d_q;
        y_d        = y_q;
        ret_d      = ret_q;
        rf_we      = 1'b0;
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        halted_o   = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Held low while reset is asserted so an aborted fetch is never presented.
                imem_req_o = reset_i;
                if (imem_ack_i) begin
                    ir_d    = imem_rdata_i;
                    pc_d    = pc_q + AW'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = rf_q[rs1];
                b_d = (op == OP_ALUR || op == OP_CMOV) ? rf_q[rs2] : imm_dw;
                d_d = rf_q[rd];
                if (op == OP_HALT) begin
                    ret_d   = ret_q + 32'd1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_ALUR, OP_ALUI: begin
                        y_d     = alu;
                        state_d = S_WB;
                    end
                    OP_LD, OP_ST: begin
                        y_d     = a_q + b_q;
                        state_d = S_MEM;
                    end
                    OP_BR: begin
                        // pc_q already points past the branch.
                        if (br_taken) pc_d = pc_q + imm_aw;
                        ret_d   = ret_q + 32'd1;
                        state_d = S_FETCH;
                    end
                    OP_CMOV: begin
                        y_d     = a_q;
                        state_d = S_WB;
                    end
                    default: begin
                        ret_d   = ret_q + 32'd1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req_o = reset_i;
                dmem_we_o  = reset_i && (op == OP_ST);
                if (dmem_ack_i) begin
                    if (op == OP_LD) begin
                        y_d     = dmem_rdata_i;
                        state_d = S_WB;
                    end else begin
                        ret_d   = ret_q + 32'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we   = (op != OP_CMOV) || (b_q != '0);
                ret_d   = ret_q + 32'd1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted_o = 1'b1;
                if (continue_i) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            y_q     <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            y_q     <= y_d;
            ret_q   <= ret_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[rd] <= y_q;
        end
    end

    assign imem_addr_o  = pc_q;
    assign dmem_addr_o  = AW'(y_q);
    assign dmem_wdata_o = d_q;
    assign debug_o      = rf_q[dbg_sel_i];
    assign retired_o    = ret_q;

endmodule

// File: tb/tb_mc_cpu_core.sv
// Bench for mc_cpu_core: wait-state memory responders, an instruction-level reference model
// predicting registers, memory, fetch trace, retire count and cycle count, directed and random programs.
module tb_mc_cpu_core;

    localparam logic [31:0] RST_PC = 32'h100;
    localparam logic [31:0] HALT_W = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cont = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic [3:0]  dbg_sel = '0;
    logic [31:0] debug;
    logic        halted;
    logic [31:0] retired;

    mc_cpu_core #(.DW(32), .AW(32), .RESET_PC(RST_PC)) dut (
        .clk_i(clk), .reset_i(reset), .continue_i(cont),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata), .imem_ack_i(imem_ack),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .dmem_rdata_i(dmem_rdata), .dmem_ack_i(dmem_ack),
        .dbg_sel_i(dbg_sel), .debug_o(debug), .halted_o(halted), .retired_o(retired)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [256];
    logic [31:0] dmem_arr [64];
    logic [31:0] m_r [16];
    logic [31:0] m_d [64];
    logic [31:0] exp_fetch [$];
    logic [31:0] act_fetch [$];
    int n_chk = 0, n_pass = 0;
    int idly = 0, ddly = 0, icnt = 0, dcnt = 0;
    bit resp_en = 1'b1;
    int dcyc = 0, last_dcyc = 0;
    bit dstable = 1'b1, last_stable = 1'b0;
    logic [31:0] daddr0 = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [31:0] ifetch(input logic [31:0] a);
        logic [31:0] w;
        w = (a - RST_PC) >> 2;
        if (w < 32'd256) return imem[w[7:0]];
        return HALT_W;
    endfunction

    function automatic logic [31:0] enc(input int op, input int fn, input int rs1, input int rs2, input logic [15:0] lo);
        enc = {op[3:0], fn[3:0], rs1[3:0], rs2[3:0], lo};
    endfunction

    // Memory responders: ack after a fixed number of wait cycles per request.
    always @(negedge clk) begin
        if (resp_en) begin
            if (!imem_req) begin imem_ack = 1'b0; icnt = 0; end
            else if (icnt >= idly) begin imem_ack = 1'b1; imem_rdata = ifetch(imem_addr); end
            else icnt++;
            if (!dmem_req) begin dmem_ack = 1'b0; dcnt = 0; end
            else if (dcnt >= ddly) begin dmem_ack = 1'b1; dmem_rdata = dmem_arr[dmem_addr[7:2]]; end
            else dcnt++;
        end
    end

    always @(posedge clk) begin
        if (reset && imem_req && imem_ack) act_fetch.push_back(imem_addr);
        if (reset && dmem_req) begin
            if (dcyc == 0) begin daddr0 = dmem_addr; dstable = 1'b1; end
            else if (dmem_addr != daddr0) dstable = 1'b0;
            dcyc++;
            if (dmem_ack) begin
                if (dmem_we) dmem_arr[dmem_addr[7:2]] = dmem_wdata;
                last_dcyc = dcyc; last_stable = dstable; dcyc = 0;
            end
        end else if (!reset) dcyc = 0;
    end

    function automatic logic [31:0] m_alu(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ~a;
            4'd6: return a << b[4:0];
            4'd7: return a >> b[4:0];
            4'd8: return $signed(a) >>> b[4:0];
            4'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Instruction-level execution from reset until the first HALT.
    task automatic model_run(output int cyc, output int ret);
        logic [31:0] pc, ins, imm, a, ea;
        logic [3:0] op, fn, rd;
        bit tk;
        pc = RST_PC; cyc = 0; ret = 0;
        exp_fetch.delete();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        for (int i = 0; i < 64; i++) m_d[i] = dmem_arr[i];
        for (int n = 0; n < 500; n++) begin
            exp_fetch.push_back(pc);
            ins = ifetch(pc);
            pc = pc + 4;
            cyc += 1 + idly;
            ret++;
            op = ins[31:28]; fn = ins[27:24]; rd = ins[15:12];
            imm = {{16{ins[15]}}, ins[15:0]};
            a = m_r[ins[23:20]];
            if (op == 4'd15) begin cyc += 1; break; end
            case (op)
                4'd0: begin m_r[rd] = m_alu(fn, a, m_r[ins[19:16]]); cyc += 3; end
                4'd1: begin m_r[rd] = m_alu(fn, a, imm); cyc += 3; end
                4'd2: begin ea = a + imm; m_r[rd] = m_d[ea[7:2]]; cyc += 4 + ddly; end
                4'd3: begin ea = a + imm; m_d[ea[7:2]] = m_r[rd]; cyc += 3 + ddly; end
                4'd4: begin
                    tk = (fn == 0) || (fn == 1 && a == 0) || (fn == 2 && a != 0) || (fn == 3 && $signed(a) < 0);
                    if (tk) pc = pc + imm;
                    cyc += 2;
                end
                4'd5: begin if (m_r[ins[19:16]] != 0) m_r[rd] = a; cyc += 3; end
                default: cyc += 2;
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retired", retired, 0);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i); #1;
            chk($sformatf("rst_reg%0d", i), debug, 0);
        end
        @(posedge clk); #2 reset = 1'b1;
        act_fetch.delete();
        #1;
        chk("rel_imem_req", imem_req, 1);
        chk("rel_imem_addr", imem_addr, RST_PC);
    endtask

    task automatic run_prog(input int chk_cyc, input int chk_ret, output int cyc);
        cyc = 0;
        while (!halted && cyc < 3000) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (cyc == chk_cyc) chk("retired_at", retired, chk_ret);
        end
        chk("halted", halted, 1);
    endtask

    task automatic compare_all(input string t, input int m_cyc, input int m_ret, input int cyc);
        int n;
        chk({t, "_cycles"}, cyc, m_cyc);
        chk({t, "_retired"}, retired, m_ret);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i); #1;
            chk($sformatf("%s_r%0d", t, i), debug, m_r[i]);
        end
        for (int i = 0; i < 64; i++) chk($sformatf("%s_mem%0d", t, i), dmem_arr[i], m_d[i]);
        chk({t, "_nfetch"}, act_fetch.size(), exp_fetch.size());
        n = (act_fetch.size() < exp_fetch.size()) ? act_fetch.size() : exp_fetch.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_fetch%0d", t, i), act_fetch[i], exp_fetch[i]);
    endtask

    initial begin
        int m_cyc, m_ret, cyc, k;
        logic [31:0] ins, saved;

        // Directed program
        for (int i = 0; i < 256; i++) imem[i] = HALT_W;
        for (int i = 0; i < 64; i++) dmem_arr[i] = $urandom;
        imem[0]  = enc(1, 0, 14, 0, 16'h0005);   // R0  = 5
        imem[1]  = enc(1, 0, 14, 0, 16'hFFFD);   // R15 = -3
        imem[2]  = enc(5, 0, 0, 0, 16'h1000);    // R1  = R0
        imem[3]  = enc(5, 0, 15, 15, 16'h2000);  // R2  = R15
        imem[4]  = enc(0, 0, 1, 2, 16'h3000);    // R3  = R1 + R2
        imem[5]  = enc(0, 8, 2, 1, 16'h4000);    // R4  = R2 >>> R1
        imem[6]  = enc(3, 0, 14, 0, 16'h3040);   // ST R3
        imem[7]  = enc(2, 0, 14, 0, 16'h5040);   // LD R5
        imem[8]  = enc(4, 0, 0, 0, 16'h0004);    // BR always +4
        imem[9]  = enc(0, 1, 1, 1, 16'h1000);    // R1 = R1 - R1
        imem[10] = enc(4, 2, 1, 0, 16'hFFF8);    // BR R1 != 0, -8
        imem[11] = enc(1, 0, 14, 0, 16'h6000);   // R6 = 0x6000
        imem[12] = enc(5, 0, 3, 14, 16'h6000);   // CMOV R6, R3, R14 (not taken)
        imem[13] = HALT_W;
        idly = 0; ddly = 3;
        model_run(m_cyc, m_ret);
        do_reset();
        run_prog(16, 4, cyc);
        compare_all("dir", m_cyc, m_ret, cyc);
        dbg_sel = 4'd3; #1 chk("dir_R3", debug, 32'd2);
        dbg_sel = 4'd4; #1 chk("dir_R4", debug, 32'hFFFF_FFFF);
        dbg_sel = 4'd5; #1 chk("dir_R5", debug, 32'd2);
        dbg_sel = 4'd6; #1 chk("dir_R6", debug, 32'h6000);
        chk("dir_stmem", dmem_arr[16], 32'd2);
        chk("dir_dreq_cycles", last_dcyc, 4);
        chk("dir_daddr_stable", last_stable, 1);

        // HALT holds off fetch; a continue pulse resumes after the HALT
        repeat (3) begin @(negedge clk); chk("halt_noreq", imem_req, 0); end
        cont = 1'b1;
        @(posedge clk); @(negedge clk); cont = 1'b0; #1;
        chk("cont_halted", halted, 0);
        chk("cont_req", imem_req, 1);
        chk("cont_addr", imem_addr, RST_PC + 32'h38);
        run_prog(-1, 0, cyc);
        chk("cont_retired", retired, m_ret + 1);

        // Random programs
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 256; i++) imem[i] = HALT_W;
            for (int i = 0; i < 64; i++) dmem_arr[i] = $urandom;
            for (int i = 0; i < 24; i++) begin
                ins = $urandom;
                k = $urandom_range(0, 7);
                case (k)
                    6: ins[31:28] = 4'($urandom_range(6, 14));
                    7: ins[31:28] = 4'd0;
                    default: ins[31:28] = 4'(k);
                endcase
                if (ins[31:28] == 4'd4) ins[15:0] = 16'(4 * $urandom_range(0, 3));
                imem[i] = ins;
            end
            idly = $urandom_range(0, 2); ddly = $urandom_range(0, 2);
            model_run(m_cyc, m_ret);
            do_reset();
            run_prog(-1, 0, cyc);
            compare_all($sformatf("rnd%0d", p), m_cyc, m_ret, cyc);
        end

        // Reset during a pending store, then a stray ack
        for (int i = 0; i < 256; i++) imem[i] = HALT_W;
        imem[0] = enc(3, 0, 14, 0, 16'h1010);
        idly = 0; ddly = 5;
        do_reset();
        k = 0;
        while (!dmem_req && k < 50) begin @(negedge clk); k++; end
        chk("mid_dreq_seen", dmem_req, 1);
        resp_en = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; reset = 1'b0;
        saved = dmem_arr[4];
        @(posedge clk); #1;
        chk("mid_dreq_dropped", dmem_req, 0);
        chk("mid_pc", imem_addr, RST_PC);
        @(negedge clk); reset = 1'b1; dmem_ack = 1'b1;
        @(posedge clk); @(negedge clk); dmem_ack = 1'b0; #1;
        chk("stray_retired", retired, 0);
        chk("stray_halted", halted, 0);
        chk("stray_pc", imem_addr, RST_PC);
        chk("stray_fetching", imem_req, 1);
        chk("stray_dreq", dmem_req, 0);
        chk("stray_mem", dmem_arr[4], saved);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
